fifo_new: RTL and testbench
===========================

# fifo_new

Single-clock synchronous FIFO, 32-bit wide, parameterised depth, with registered read data and full/empty status. It buffers telemetry words between the bit-stream front end and the Rice decoder: the producer writes whenever it has a word and `full` is low, and the decoder reads whenever it needs a word and `empty` is low.

## Interface
Parameters:
- `DATA_W`, 32, word width in bits.
- `DEPTH`, 16, number of storage entries; must be a power of two and ≥ 2.

Ports:
- `clk`  input  1  single clock; all state changes on the rising edge.
- `rst`  input  1  reset, asynchronous, active-low (asserted when 0).
- `wr_en`  input  1  write request.
- `din`  input  DATA_W  write data, sampled on the rising edge when a write is accepted.
- `rd_en`  input  1  read request.
- `dout`  output  DATA_W  registered read data.
- `full`  output  1  high when DEPTH words are stored.
- `empty`  output  1  high when 0 words are stored.
- `count`  output  $clog2(DEPTH)+1  stored-word count; present only with `FIFO_COUNT_EN`.

## Operation
- Storage: DEPTH x DATA_W register array. Write and read pointers are $clog2(DEPTH)+1 bits wide; the extra MSB is the wrap bit.
- Write accepted when `wr_en && !full`: `mem[wptr] <= din`, and `wptr` increments.
- Read accepted when `rd_en && !empty`: `dout <= mem[rptr]`, and `rptr` increments.
- A rejected request has no effect. No error flag is raised. A blocked write leaves `mem` and `wptr` unchanged. A blocked read leaves `dout` unchanged.
- Simultaneous read and write:
  - Neither full nor empty: both are accepted and the occupancy is unchanged.
  - While full: only the read is accepted; the write is dropped.
  - While empty: only the write is accepted; the read is ignored and `dout` holds.
- `empty = (wptr == rptr)`.
- `full = (wptr[MSB] != rptr[MSB]) && (low address bits equal)`.
- Pointers wrap naturally modulo 2*DEPTH, with no special case at the wrap.
- `dout` holds its last value until the next accepted read.

## Timing
- Reset (`rst` = 0, asynchronous): `wptr = 0`, `rptr = 0`, `dout = 0`, `empty = 1`, `full = 0`, `count = 0`. Memory contents are not reset.
- Reset asserted mid-operation discards all stored words immediately, without waiting for a clock edge.
- Operation resumes on the first rising edge after `rst` returns to 1.
- `full` and `empty` are combinational from the registered pointers, so they update in the same cycle as the pointer change.
- Write-to-empty-deassert: 1 cycle.
- Read latency: data appears on `dout` 1 cycle after the accepting edge.
- A word written at edge N can be read at edge N+1 and appears on `dout` after edge N+1.

## Configuration
- `FIFO_COUNT_EN` defined: the `count` port exists and equals `wptr - rptr` (range 0..DEPTH). It is combinational from the pointers and updates alongside `full`/`empty`.
- `FIFO_COUNT_EN` undefined: the `count` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `fifo_pkg`:
  - `FIFO_DATA_W = 32`
  - `FIFO_DEPTH = 16`
  - a typedef `fifo_word_t` of `logic [FIFO_DATA_W-1:0]`
- Single module; no sub-module needed. The pointer/flag logic stays inline.

## Test plan
- Reset: hold `rst` = 0 for 2 ns, then release. Required: `empty` = 1, `full` = 0, `dout` = 0, `count` = 0. Asserting `rst` mid-stream clears the flags immediately.
- Burst write then read: write 1010101011..1010101015 (5 words) on consecutive cycles, then assert `rd_en` for 5 cycles.
  - `dout` shows 1010101011..1010101015 in order, each one cycle after its read edge.
  - `empty` returns to 1 after the 5th read.
- Fill to full: write 16 words 0..15. Required: `full` = 1 after the 16th write. A 17th write of 99 is dropped; reading all 16 returns 0..15.
- Read while empty: pulse `rd_en` with no data. Required: `dout` unchanged, `empty` stays 1, pointers do not move.
- Simultaneous read/write:
  - With 3 words stored, assert `wr_en` and `rd_en` for 10 cycles: occupancy stays 3 and output order is preserved.
  - While full, simultaneous read/write reads the oldest word and drops the write (`count` goes 16 to 15).
- Wrap-around: perform 40 write/read pairs. Data matches a reference queue throughout, and `full`/`empty` stay correct across the pointer wrap.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and word type for the telemetry FIFO.
package fifo_pkg;
  localparam int FIFO_DATA_W = 32;
  localparam int FIFO_DEPTH  = 16;
  typedef logic [FIFO_DATA_W-1:0] fifo_word_t;
endpackage

// File: rtl/fifo_new_if.sv
// Producer/consumer bus for fifo_new; count exists only when FIFO_COUNT_EN is defined.
interface fifo_new_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
);
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              full;
  logic              empty;
`ifdef FIFO_COUNT_EN
  logic [$clog2(DEPTH):0] count;
`endif

  modport master (
    output wr_en, din, rd_en,
`ifdef FIFO_COUNT_EN
    input  count,
`endif
    input  dout, full, empty
  );

  modport slave (
    input  wr_en, din, rd_en,
`ifdef FIFO_COUNT_EN
    output count,
`endif
    output dout, full, empty
  );
endinterface

// File: rtl/fifo_new.sv
// Single-clock FIFO with registered read data and wrap-bit pointers.
// Optional occupancy port enabled by defining FIFO_COUNT_EN.
module fifo_new
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  fifo_new_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("fifo_new: DEPTH must be a power of two and >= 2");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [DATA_W-1:0] dout_q;
  logic              full, empty, wr_ok, rd_ok;

  // Extra pointer MSB distinguishes full from empty when addresses match.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign wr_ok = bus.wr_en && !full;
  assign rd_ok = bus.rd_en && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr   <= '0;
      rptr   <= '0;
      dout_q <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) begin
        dout_q <= mem[rptr[AW-1:0]];
        rptr   <= rptr + PW'(1);
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= bus.din;
  end

  assign bus.dout  = dout_q;
  assign bus.full  = full;
  assign bus.empty = empty;
`ifdef FIFO_COUNT_EN
  assign bus.count = wptr - rptr;
`endif
endmodule

// File: tb/tb_fifo_new.sv
// Directed + random bench for fifo_new against a queue model of occupancy and order.
module tb_fifo_new;
  import fifo_pkg::*;
  localparam int DEPTH = FIFO_DEPTH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_new_if #(.DATA_W(FIFO_DATA_W), .DEPTH(DEPTH)) bus ();
  fifo_new #(.DATA_W(FIFO_DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  fifo_word_t q[$];
  fifo_word_t dout_exp;
  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, " dout"}, bus.dout, dout_exp);
    check({tag, " full"}, 32'(bus.full), 32'(q.size() == DEPTH));
    check({tag, " empty"}, 32'(bus.empty), 32'(q.size() == 0));
`ifdef FIFO_COUNT_EN
    check({tag, " count"}, 32'(bus.count), 32'(q.size()));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, check 1 ns later.
  task automatic step(input string tag, input logic we, input fifo_word_t d, input logic re);
    bit wa, ra;
    @(negedge clk);
    bus.wr_en = we;
    bus.din   = d;
    bus.rd_en = re;
    @(posedge clk);
    wa = we && (q.size() < DEPTH);
    ra = re && (q.size() != 0);
    if (ra) dout_exp = q.pop_front();
    if (wa) q.push_back(d);
    #1 check_state(tag);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    #2 rst = 1'b0;
    #1;
    q.delete();
    dout_exp = '0;
    check_state(tag);
    #1 rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    dout_exp  = '0;
    #1 check_state("reset");
    #1 rst = 1'b1;

    // Burst of 5 then read back
    for (int i = 0; i < 5; i++) step("burst_wr", 1'b1, fifo_word_t'(1010101011 + i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      step("burst_rd", 1'b0, '0, 1'b1);
      check("burst_order", bus.dout, fifo_word_t'(1010101011 + i));
    end

    // Fill to full, overflow write dropped, drain
    for (int i = 0; i < DEPTH; i++) step("fill_wr", 1'b1, fifo_word_t'(i), 1'b0);
    check("full_after_fill", 32'(bus.full), 32'd1);
    step("overflow_wr", 1'b1, fifo_word_t'(99), 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      step("drain_rd", 1'b0, '0, 1'b1);
      check("drain_order", bus.dout, fifo_word_t'(i));
    end

    // Read while empty leaves dout and pointers alone
    step("empty_rd", 1'b0, '0, 1'b1);
    step("empty_rd2", 1'b0, '0, 1'b1);
    check("empty_rd_hold", bus.dout, fifo_word_t'(DEPTH - 1));
    step("post_empty_wr", 1'b1, fifo_word_t'(32'hCAFE), 1'b0);
    step("post_empty_rd", 1'b0, '0, 1'b1);
    check("post_empty_data", bus.dout, fifo_word_t'(32'hCAFE));

    // Simultaneous read/write with 3 stored
    for (int i = 0; i < 3; i++) step("sim_pre", 1'b1, fifo_word_t'($urandom), 1'b0);
    for (int i = 0; i < 10; i++) step("sim_rw", 1'b1, fifo_word_t'($urandom), 1'b1);
    check("sim_occupancy", 32'(q.size()), 32'd3);
    // Top up to full, then simultaneous r/w while full
    while (q.size() < DEPTH) step("sim_fill", 1'b1, fifo_word_t'($urandom), 1'b0);
    step("full_rw", 1'b1, fifo_word_t'(32'hDEAD), 1'b1);
    check("full_rw_occ", 32'(q.size()), 32'(DEPTH - 1));
    while (q.size() > 0) step("sim_drain", 1'b0, '0, 1'b1);

    // Wrap-around: 40 write/read pairs, well past 2*DEPTH pointer range
    for (int i = 0; i < 40; i++) begin
      step("wrap_wr", 1'b1, fifo_word_t'($urandom), 1'b0);
      step("wrap_rd", 1'b0, '0, 1'b1);
    end

    // Random mix with write bias then read bias to hit both flags
    for (int i = 0; i < 150; i++)
      step("rand_wbias", ($urandom_range(0, 3) != 0), fifo_word_t'($urandom), ($urandom_range(0, 3) == 0));
    for (int i = 0; i < 150; i++)
      step("rand_rbias", ($urandom_range(0, 3) == 0), fifo_word_t'($urandom), ($urandom_range(0, 3) != 0));

    // Asynchronous reset while full clears flags without a clock edge
    while (q.size() < DEPTH) step("pre_rst_fill", 1'b1, fifo_word_t'($urandom), 1'b0);
    step("pre_rst_rd", 1'b0, '0, 1'b1);
    step("pre_rst_wr", 1'b1, fifo_word_t'($urandom), 1'b0);
    async_reset("midrst");
    for (int i = 0; i < 4; i++) step("resume_wr", 1'b1, fifo_word_t'(100 + i), 1'b0);
    for (int i = 0; i < 4; i++) step("resume_rd", 1'b0, '0, 1'b1);
    check("resume_last", bus.dout, fifo_word_t'(103));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
